// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - 2-bit saturating-counter branch history table with mispredict stats
module branch_predictor_bht #(
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    input  logic             stall,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             resolve_valid,
    input  logic [31:0]      resolve_pc,
    input  logic             resolve_taken,
    input  logic             resolve_pred_taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int DEPTH = 1 << INDEX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]         tbl [DEPTH];
    logic [INDEX_W-1:0] fidx;
    logic [INDEX_W-1:0] ridx;
    logic [1:0]         rcur;
    logic [1:0]         rnext;
    logic               look_bit;
    logic               mis_event;

    assign fidx      = fetch_pc[INDEX_W+1:2];
    assign ridx      = resolve_pc[INDEX_W+1:2];
    assign mis_event = resolve_valid & (resolve_taken ^ resolve_pred_taken);

    always_comb begin
        rcur  = tbl[ridx];
        rnext = rcur;
        if (resolve_taken) begin
            if (rcur != 2'b11) rnext = rcur + 2'd1;
        end else begin
            if (rcur != 2'b00) rnext = rcur - 2'd1;
        end
    end

    // Write-first: a same-cycle update to the looked-up entry is visible to the lookup.
    always_comb begin
        look_bit = tbl[fidx][1];
        if (resolve_valid && (ridx == fidx)) look_bit = rnext[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= 2'b01;
        end else if (resolve_valid) begin
            tbl[ridx] <= rnext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else if (!stall) begin
            pred_valid <= fetch_valid;
            pred_taken <= fetch_valid & look_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= mis_event;
            if (resolve_valid && (branch_count != CNT_MAX))
                branch_count <= branch_count + CNT_ONE;
            if (mis_event && (mispredict_count != CNT_MAX))
                mispredict_count <= mispredict_count + CNT_ONE;
        end
    end
endmodule
